// File: rtl/demux_ctrl_pkg.sv
// Shared types and helpers for the 1-to-4 dispatch controller.
// Holds the FSM state encoding, channel-select type and one-hot decode.
package demux_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_sel_t;

  function automatic logic [3:0] onehot4(input ch_sel_t sel);
    logic [3:0] vec;
    vec      = 4'b0000;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dispatch_sat_counter.sv
// Saturating delivery counter; a synchronous clear takes priority over an increment.
module dispatch_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count register: clear, saturating increment, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-entry holding buffer that steers each accepted word to one of four channels,
// either round-robin with stall-skip or by a per-word destination field.
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [1:0]            dest_i,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [3:0]            out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic [3:0]            out_ready,
  output logic [1:0]            out_sel,
  output logic                  busy,
  input  logic                  clr_cnt,
  output logic [4*CNT_W-1:0]    cnt_o
);

  localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  state_t              state_r, next_state_s;
  ch_sel_t             sel_r, next_sel_s;
  ch_sel_t             ptr_r, next_ptr_s;
  logic [STALL_W-1:0]  stall_r, next_stall_s;
  logic                mode_r;
  logic [DATA_W-1:0]   data_r;
  logic [3:0]          valid_r;
  logic                capture_s;
  logic                deliver_s;
  logic [3:0]          inc_s;

  assign in_ready  = (state_r == IDLE) ? 1'b1 : out_ready[sel_r];
  assign capture_s = in_valid & in_ready;
  assign deliver_s = (state_r == HOLD) & out_ready[sel_r];
  assign inc_s     = deliver_s ? onehot4(sel_r) : 4'b0000;

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_sel   = sel_r;
  assign busy      = (state_r == HOLD);

  // Next-state, steering and stall-rotation decisions.
  always_comb begin
    next_state_s = state_r;
    next_sel_s   = sel_r;
    next_ptr_s   = ptr_r;
    next_stall_s = stall_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          next_state_s = HOLD;
          next_sel_s   = mode ? dest_i : ptr_r;
          next_stall_s = {STALL_W{1'b0}};
        end else begin
          next_state_s = IDLE;
        end
      end
      HOLD: begin
        if (deliver_s) begin
          next_ptr_s = sel_r + 2'd1;
          if (capture_s) begin
            // Back-to-back: the new word steers from the just-advanced pointer.
            next_state_s = HOLD;
            next_sel_s   = mode ? dest_i : (sel_r + 2'd1);
            next_stall_s = {STALL_W{1'b0}};
          end else begin
            next_state_s = IDLE;
          end
        end else if (!mode_r) begin
          if (stall_r == STALL_LAST) begin
            next_sel_s   = sel_r + 2'd1;
            next_stall_s = {STALL_W{1'b0}};
          end else begin
            next_stall_s = stall_r + STALL_ONE;
          end
        end else begin
          next_stall_s = stall_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Steering, buffer and registered channel-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r   <= 2'd0;
      ptr_r   <= 2'd0;
      stall_r <= {STALL_W{1'b0}};
      mode_r  <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 4'b0000;
    end else begin
      sel_r   <= next_sel_s;
      ptr_r   <= next_ptr_s;
      stall_r <= next_stall_s;
      valid_r <= (next_state_s == HOLD) ? onehot4(next_sel_s) : 4'b0000;
      if (capture_s) begin
        data_r <= in_data;
        mode_r <= mode;
      end else begin
        data_r <= data_r;
        mode_r <= mode_r;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    dispatch_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (inc_s[k]),
      .cnt   (cnt_o[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed and randomized checks of demux_dispatch_ctrl against a transaction-level model.
module tb_demux_dispatch_ctrl;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 2;
  localparam int STALL_MAX = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                mode;
  logic [1:0]          dest_i;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic [3:0]          out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [3:0]          out_ready;
  logic [1:0]          out_sel;
  logic                busy;
  logic                clr_cnt;
  logic [4*CNT_W-1:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  // reference model: the held word, where it points, how long it has waited there
  bit          m_held;
  int          m_word;
  int          m_sel;
  int          m_ptr;
  int          m_wait;
  bit          m_mode;
  int          m_cnt[4];

  demux_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dest_i(dest_i),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_sel(out_sel), .busy(busy), .clr_cnt(clr_cnt), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_word = 0; m_sel = 0; m_ptr = 0; m_wait = 0; m_mode = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  function automatic logic [4*CNT_W-1:0] model_cnt();
    logic [4*CNT_W-1:0] v;
    for (int k = 0; k < 4; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    return v;
  endfunction

  // compare every observable output with the model, then advance model and clock
  task automatic cyc();
    bit exp_ready, delivered, captured;
    #1;
    exp_ready = !m_held || out_ready[m_sel];
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {28'd0, out_valid}, m_held ? (32'd1 << m_sel) : 32'd0);
    chk("out_data", {24'd0, out_data}, m_word);
    chk("out_sel", {30'd0, out_sel}, m_sel);
    chk("busy", {31'd0, busy}, {31'd0, m_held});
    chk("cnt_o", {24'd0, cnt_o}, {24'd0, model_cnt()});
    delivered = m_held && out_ready[m_sel];
    captured  = in_valid && exp_ready;
    if (delivered) begin
      if (m_cnt[m_sel] < CMAX) m_cnt[m_sel]++;
      m_ptr = (m_sel + 1) % 4;
    end
    if (clr_cnt) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    if (captured) begin
      m_word = in_data; m_mode = mode; m_held = 1; m_wait = 0;
      m_sel  = mode ? int'(dest_i) : m_ptr;
    end else if (delivered) begin
      m_held = 0;
    end else if (m_held && !m_mode) begin
      m_wait++;
      if (m_wait == STALL_MAX) begin
        m_sel  = (m_sel + 1) % 4;
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; clr_cnt = 1'b0; mode = 1'b0; dest_i = 2'd0;
    in_data = 8'h00; out_ready = 4'b0000;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // round-robin streaming, five words back to back
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      cyc();
      chk("rr_stream_sel", {30'd0, out_sel}, i % 4);
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("rr_stream_cnt", {24'd0, cnt_o}, 32'b01_01_01_10);
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;

    // stall skip from pointer 1, only channel 0 ready
    out_ready = 4'b0001; in_valid = 1'b1; in_data = 8'h77;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("stall_sel", {30'd0, out_sel}, 1 + i / 4);
      cyc();
    end
    chk("stall_final_sel", {30'd0, out_sel}, 32'd0);
    cyc();
    chk("stall_cnt0", {24'd0, cnt_o}, 32'b00_00_00_01);

    // directed to channel 2, ten cycles of backpressure
    mode = 1'b1; dest_i = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b0000;
    cyc();
    in_valid = 1'b0; mode = 1'b0; dest_i = 2'd0;
    for (int i = 0; i < 10; i++) begin
      chk("dir_wait_valid", {28'd0, out_valid}, 32'b0100);
      chk("dir_wait_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    out_ready = 4'b0100;
    cyc();
    chk("dir_cnt2", {24'd0, cnt_o[4 +: 2]}, 32'd1);
    out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    chk("dir_next_ptr", {30'd0, out_sel}, 32'd3);
    out_ready = 4'b1000;
    cyc();

    // saturation and clear on channel 3
    clr_cnt = 1'b1; out_ready = 4'b0000; cyc(); clr_cnt = 1'b0;
    mode = 1'b1; dest_i = 2'd3; out_ready = 4'b1000; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'hC0 + i);
      cyc();
    end
    chk("sat_cnt3", {24'd0, cnt_o[6 +: 2]}, 32'd3);
    in_valid = 1'b0; clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_wins", {24'd0, cnt_o}, 32'd0);

    // asynchronous reset while holding a word on channel 2
    mode = 1'b1; dest_i = 2'd2; in_data = 8'h5A; in_valid = 1'b1; out_ready = 4'b0000;
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 4'b1111;
    cyc();
    out_ready = 4'b0000; mode = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    cyc();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {28'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_sel", {30'd0, out_sel}, 32'd0);
    chk("arst_cnt", {24'd0, cnt_o}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    cyc();
    in_valid = 1'b0;
    chk("arst_first_ch0", {28'd0, out_valid}, 32'b0001);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      mode      = 1'($urandom);
      dest_i    = 2'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      clr_cnt   = 1'($urandom_range(0, 40) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
